pc_ir_unit: RTL and testbench

Program-counter, instruction-register and status-register stage of the 16-bit multicycle CPU. It sits directly downstream of `control` and consumes its `e_pc`, `IorD`, `we_ir`, `pc_src`, `pc_jp`, `e_flag`, `e_out_r` and `done` strobes. It also feeds `control` back its `instr` word and the registered `n/z/c/v` flags. It owns every piece of architectural state in the datapath except the register file and memory.

---
 rtl/pc_ir_unit.sv | 144 ++++++++++++++
 tb/tb_pc_ir_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_ir_unit.sv
// pc_ir_unit: program counter, instruction register, status flags, OUTR
// register and halt latch for the 16-bit multicycle CPU.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   cpu_on            run enable; state holds when low
//   e_pc, pc_src,
//   pc_jp[1:0]        PC load strobe and source select
//   IorD              memory address select (1 = daddr, 0 = pc)
//   we_ir             IR load strobe (captures mem_rdata)
//   e_flag            flag load strobe (captures alu_n/z/c/v)
//   e_out_r           OUTR load strobe (captures reg_rd)
//   done              sets the sticky halt latch
//   alu_y, alu_*      ALU result and flags
//   reg_rd, daddr     register-file Rd and datapath data address
//   mem_rdata         synchronous memory read data
//   mem_addr          combinational memory address
//   pc, instr         current PC and IR
//   n/z/c/v_flag      registered flags
//   out_data/valid    OUTR contents and one-cycle valid pulse
//   halted            sticky halt indicator
//   jump_cnt          (only with PC_JUMP_CNT_EN) saturating count of taken
//                     non-sequential PC loads
//
// Optional feature macro: PC_JUMP_CNT_EN.
module pc_ir_unit #(
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_on,
  input  logic          e_pc,
  input  logic          IorD,
  input  logic          we_ir,
  input  logic          pc_src,
  input  logic [1:0]    pc_jp,
  input  logic          e_flag,
  input  logic          e_out_r,
  input  logic          done,
  input  logic [15:0]   alu_y,
  input  logic          alu_n,
  input  logic          alu_z,
  input  logic          alu_c,
  input  logic          alu_v,
  input  logic [15:0]   reg_rd,
  input  logic [AW-1:0] daddr,
  input  logic [15:0]   mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] pc,
  output logic [15:0]   instr,
  output logic          n_flag,
  output logic          z_flag,
  output logic          c_flag,
  output logic          v_flag,
  output logic [15:0]   out_data,
  output logic          out_valid,
`ifdef PC_JUMP_CNT_EN
  output logic [15:0]   jump_cnt,
`endif
  output logic          halted
);

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  flags_t          flags;
  logic            live;
  logic [AW-1:0]   pc_nxt;
  logic [15:0]     pc16;
  logic [15:0]     br_off;
  logic [15:0]     jmp_tgt;

  assign live     = cpu_on & ~halted;
  assign mem_addr = IorD ? daddr : pc;

  // Jump targets are formed at 16 bits and truncated to AW, so the branch
  // offset sign extension and the 11-bit page splice work for any AW.
  always_comb begin
    pc16         = '0;
    pc16[AW-1:0] = pc;
  end
  assign br_off  = {{8{instr[7]}}, instr[7:0]};
  assign jmp_tgt = {pc16[15:11], instr[10:0]};

  always_comb begin
    pc_nxt = pc;
    if (e_pc) begin
      if (!pc_src) pc_nxt = alu_y[AW-1:0];
      else begin
        case (pc_jp)
          2'b00:   pc_nxt = pc + br_off[AW-1:0];
          2'b01:   pc_nxt = jmp_tgt[AW-1:0];
          2'b10:   pc_nxt = reg_rd[AW-1:0];
          default: pc_nxt = pc;  // reserved encoding: hold
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      instr     <= '0;
      flags     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      // The valid pulse is driven every cycle so it never lingers past
      // the cycle after its OUTR load.
      out_valid <= live & e_out_r;
      if (live) begin
        pc <= pc_nxt;
        // IR captures data fetched from the old PC even when PC moves
        // on the same edge.
        if (we_ir)   instr    <= mem_rdata;
        if (e_flag)  flags    <= '{n: alu_n, z: alu_z, c: alu_c, v: alu_v};
        if (e_out_r) out_data <= reg_rd;
        if (done)    halted   <= 1'b1;
      end
    end
  end

  assign n_flag = flags.n;
  assign z_flag = flags.z;
  assign c_flag = flags.c;
  assign v_flag = flags.v;

`ifdef PC_JUMP_CNT_EN
  logic jump_taken;
  assign jump_taken = live & e_pc & pc_src & (pc_jp != 2'b11);

  always_ff @(posedge clk) begin
    if (reset)                                jump_cnt <= '0;
    else if (jump_taken && jump_cnt != 16'hFFFF) jump_cnt <= jump_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pc_ir_unit.sv
module tb_pc_ir_unit;

  localparam int            AW  = 16;
  localparam logic [15:0]   RPC = 16'h0010;

  logic        clk = 1'b0;
  logic        reset, cpu_on, e_pc, IorD, we_ir, pc_src, e_flag, e_out_r, done;
  logic [1:0]  pc_jp;
  logic [15:0] alu_y, reg_rd, daddr, mem_rdata;
  logic [3:0]  alu_fl;
  logic [15:0] mem_addr, pc, instr, out_data;
  logic        n_flag, z_flag, c_flag, v_flag, out_valid, halted;
`ifdef PC_JUMP_CNT_EN
  logic [15:0] jump_cnt;
`endif

  always #5 clk = ~clk;

  pc_ir_unit #(.AW(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .cpu_on(cpu_on), .e_pc(e_pc), .IorD(IorD),
    .we_ir(we_ir), .pc_src(pc_src), .pc_jp(pc_jp), .e_flag(e_flag),
    .e_out_r(e_out_r), .done(done), .alu_y(alu_y),
    .alu_n(alu_fl[3]), .alu_z(alu_fl[2]), .alu_c(alu_fl[1]), .alu_v(alu_fl[0]),
    .reg_rd(reg_rd), .daddr(daddr), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .pc(pc), .instr(instr),
    .n_flag(n_flag), .z_flag(z_flag), .c_flag(c_flag), .v_flag(v_flag),
    .out_data(out_data), .out_valid(out_valid),
`ifdef PC_JUMP_CNT_EN
    .jump_cnt(jump_cnt),
`endif
    .halted(halted)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] dut_fl();
    return {n_flag, z_flag, c_flag, v_flag};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; cpu_on = 1; e_pc = 0; IorD = 0; we_ir = 0; pc_src = 0; pc_jp = 0;
    e_flag = 0; e_out_r = 0; done = 0; alu_y = 0; alu_fl = 0; reg_rd = 0;
    daddr = 0; mem_rdata = 0;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic cpu_on, e_pc, iord, we_ir, pc_src;
    logic [1:0] jp;
    logic e_flag, e_out_r, done;
    logic [15:0] alu_y;
    logic [3:0]  fl;
    logic [15:0] reg_rd, daddr, rdata;
    logic [15:0] x_pc, x_ir;
    logic [3:0]  x_fl;
    logic [15:0] x_out;
    logic        x_ov, x_halt;
    logic [15:0] x_ma;
    string       nm;
  } vec_t;

  vec_t tv[16];

  // ---------------- reference model ----------------
  int m_pc, m_ir, m_fl, m_out, m_ov, m_halt, m_jc;

  function automatic int sext8(input int v);
    return (v & 'h80) != 0 ? (v & 'hFF) - 256 : (v & 'hFF);
  endfunction

  task automatic model_step();
    bit live;
    int npc;
    if (reset) begin
      m_pc = RPC; m_ir = 0; m_fl = 0; m_out = 0; m_ov = 0; m_halt = 0; m_jc = 0;
      return;
    end
    live = cpu_on && !m_halt;
    m_ov = (live && e_out_r) ? 1 : 0;
    if (!live) return;
    npc = m_pc;
    if (e_pc && !pc_src) npc = alu_y;
    else if (e_pc) begin
      if (pc_jp == 0)      npc = (m_pc + sext8(m_ir)) & 'hFFFF;
      else if (pc_jp == 1) npc = (m_pc & 'hF800) | (m_ir & 'h07FF);
      else if (pc_jp == 2) npc = reg_rd;
      if (pc_jp != 3 && m_jc < 65535) m_jc++;
    end
    m_pc = npc;
    if (we_ir)   m_ir  = mem_rdata;
    if (e_flag)  m_fl  = alu_fl;
    if (e_out_r) m_out = reg_rd;
    if (done)    m_halt = 1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    32'(pc),        32'(m_pc));
    check({tag, ".instr"}, 32'(instr),     32'(m_ir));
    check({tag, ".flags"}, 32'(dut_fl()),  32'(m_fl));
    check({tag, ".out"},   32'(out_data),  32'(m_out));
    check({tag, ".ov"},    32'(out_valid), 32'(m_ov));
    check({tag, ".halt"},  32'(halted),    32'(m_halt));
    check({tag, ".maddr"}, 32'(mem_addr),  IorD ? 32'(daddr) : 32'(m_pc));
`ifdef PC_JUMP_CNT_EN
    check({tag, ".jcnt"},  32'(jump_cnt),  32'(m_jc));
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".pc"},    32'(pc),        32'(RPC));
    check({tag, ".instr"}, 32'(instr),     32'h0);
    check({tag, ".flags"}, 32'(dut_fl()),  32'h0);
    check({tag, ".out"},   32'(out_data),  32'h0);
    check({tag, ".ov"},    32'(out_valid), 32'h0);
    check({tag, ".halt"},  32'(halted),    32'h0);
    check({tag, ".maddr"}, 32'(mem_addr),  32'(RPC));
  endtask

  initial begin
    //          cpu epc iod wir src jp efl eor dn  alu_y     fl     reg_rd    daddr     rdata      x_pc      x_ir      x_fl   x_out     ov  hlt x_ma
    tv[0]  = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0011, 4'h0, 16'h0000, 16'h0000, 16'hC305, 16'h0011, 16'hC305, 4'h0, 16'h0000, 0, 0, 16'h0011, "fetch"};
    tv[1]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 4'h0, 16'h0000, 16'h0000, 16'h00FE, 16'h0011, 16'h00FE, 4'h0, 16'h0000, 0, 0, 16'h0011, "ld_ir"};
    tv[2]  = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h000F, 16'h00FE, 4'h0, 16'h0000, 0, 0, 16'h000F, "br_back"};
    tv[3]  = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 16'hFFFF, 4'h0, 16'h0000, 16'h0000, 16'h0002, 16'hFFFF, 16'h0002, 4'h0, 16'h0000, 0, 0, 16'hFFFF, "pc_ffff"};
    tv[4]  = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0002, 4'h0, 16'h0000, 0, 0, 16'h0001, "br_wrap"};
    tv[5]  = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 16'hF855, 4'h0, 16'h0000, 16'h0000, 16'h8123, 16'hF855, 16'h8123, 4'h0, 16'h0000, 0, 0, 16'hF855, "setup_jmp"};
    tv[6]  = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 16'h0000, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'hF923, 16'h8123, 4'h0, 16'h0000, 0, 0, 16'hF923, "jmp"};
    tv[7]  = '{1, 1, 1, 0, 1, 2, 0, 0, 0, 16'h0000, 4'h0, 16'hABCD, 16'hBEEF, 16'h0000, 16'hABCD, 16'h8123, 4'h0, 16'h0000, 0, 0, 16'hBEEF, "jr"};
    tv[8]  = '{1, 1, 0, 0, 1, 3, 0, 0, 0, 16'h1111, 4'h0, 16'h2222, 16'h0000, 16'h0000, 16'hABCD, 16'h8123, 4'h0, 16'h0000, 0, 0, 16'hABCD, "rsvd_hold"};
    tv[9]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 4'hA, 16'h0000, 16'h0000, 16'h0000, 16'hABCD, 16'h8123, 4'hA, 16'h0000, 0, 0, 16'hABCD, "flags"};
    tv[10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 4'h5, 16'h0000, 16'h0000, 16'h0000, 16'hABCD, 16'h8123, 4'hA, 16'h0000, 0, 0, 16'hABCD, "flag_hold"};
    tv[11] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 4'h0, 16'h5A5A, 16'h0000, 16'h0000, 16'hABCD, 16'h8123, 4'hA, 16'h5A5A, 1, 0, 16'hABCD, "outr"};
    tv[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'hABCD, 16'h8123, 4'hA, 16'h5A5A, 0, 0, 16'hABCD, "ov_drop"};
    tv[13] = '{0, 1, 0, 1, 0, 0, 1, 1, 1, 16'h1234, 4'h5, 16'h7777, 16'h0000, 16'h1111, 16'hABCD, 16'h8123, 4'hA, 16'h5A5A, 0, 0, 16'hABCD, "cpu_off"};
    tv[14] = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 16'h0000, 4'h5, 16'h1357, 16'h0000, 16'h0000, 16'hABCD, 16'h8123, 4'h5, 16'h1357, 1, 1, 16'hABCD, "done"};
    tv[15] = '{1, 1, 0, 1, 0, 0, 1, 1, 0, 16'h2222, 4'hF, 16'h9999, 16'h0000, 16'h4444, 16'hABCD, 16'h8123, 4'h5, 16'h1357, 0, 1, 16'hABCD, "post_halt"};
  end

  initial begin
    idle_inputs();
    reset = 1;
    tick(); tick();
    check_reset_state("reset");
    reset = 0;

    for (int i = 0; i < 16; i++) begin
      cpu_on = tv[i].cpu_on; e_pc = tv[i].e_pc; IorD = tv[i].iord; we_ir = tv[i].we_ir;
      pc_src = tv[i].pc_src; pc_jp = tv[i].jp; e_flag = tv[i].e_flag;
      e_out_r = tv[i].e_out_r; done = tv[i].done; alu_y = tv[i].alu_y;
      alu_fl = tv[i].fl; reg_rd = tv[i].reg_rd; daddr = tv[i].daddr;
      mem_rdata = tv[i].rdata;
      tick();
      check({tv[i].nm, ".pc"},    32'(pc),        32'(tv[i].x_pc));
      check({tv[i].nm, ".instr"}, 32'(instr),     32'(tv[i].x_ir));
      check({tv[i].nm, ".flags"}, 32'(dut_fl()),  32'(tv[i].x_fl));
      check({tv[i].nm, ".out"},   32'(out_data),  32'(tv[i].x_out));
      check({tv[i].nm, ".ov"},    32'(out_valid), 32'(tv[i].x_ov));
      check({tv[i].nm, ".halt"},  32'(halted),    32'(tv[i].x_halt));
      check({tv[i].nm, ".maddr"}, 32'(mem_addr),  32'(tv[i].x_ma));
    end

    // Reset while halted and mid-instruction strobes asserted.
    idle_inputs();
    reset = 1; e_pc = 1; we_ir = 1; mem_rdata = 16'hDEAD; e_flag = 1; alu_fl = 4'hF;
    tick();
    idle_inputs();
    check_reset_state("reset2");

    // Randomized run against the reference model.
    reset = 1;
    tick();
    model_step();
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 59) == 0);
      cpu_on    = ($urandom_range(0, 9) != 0);
      e_pc      = 1'($urandom);
      IorD      = 1'($urandom);
      we_ir     = 1'($urandom);
      pc_src    = 1'($urandom);
      pc_jp     = 2'($urandom);
      e_flag    = 1'($urandom);
      e_out_r   = 1'($urandom);
      done      = ($urandom_range(0, 149) == 0);
      alu_y     = 16'($urandom);
      alu_fl    = 4'($urandom);
      reg_rd    = 16'($urandom);
      daddr     = 16'($urandom);
      mem_rdata = 16'($urandom);
      tick();
      model_step();
      check_model("rand");
    end

`ifdef PC_JUMP_CNT_EN
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    e_pc = 1; pc_src = 1;
    pc_jp = 2'b00; tick();
    pc_jp = 2'b01; tick();
    pc_jp = 2'b10; tick();
    pc_jp = 2'b11; tick();
    check("jcnt3", 32'(jump_cnt), 32'd3);
    pc_jp = 2'b10;
    for (int i = 0; i < 65532; i++) tick();
    check("jcnt_max", 32'(jump_cnt), 32'hFFFF);
    tick(); tick();
    check("jcnt_sat", 32'(jump_cnt), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
